ec_regbank: RTL and testbench

Operand register bank and writeback stage wrapped around the GF(2^233) elliptic-curve ALU. It holds eight 233-bit field-element registers. Each cycle it presents four selected registers, registered, to the ALU inputs a0..a3, together with a delayed copy of the control word. It writes the ALU results c0/c1 back on the following edge and provides a host load port and a handshaked readout port for coordinates and scalars-derived values.

---
 rtl/ec_regbank.sv | 134 +++++++++++++
 tb/tb_ec_regbank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_regbank.sv
// Operand register bank and writeback stage for the GF(2^233) EC ALU.
// Eight field-element registers, forwarded operand fetch, host load and readout.
module ec_regbank #(
    parameter int W  = 233,
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] sel0,
    input  logic [AW-1:0] sel1,
    input  logic [AW-1:0] sel2,
    input  logic [AW-1:0] sel3,
    input  logic [9:0]    cw_in,
    output logic [W-1:0]  a0,
    output logic [W-1:0]  a1,
    output logic [W-1:0]  a2,
    output logic [W-1:0]  a3,
    output logic [9:0]    cw,
    input  logic [W-1:0]  c0,
    input  logic [W-1:0]  c1,
    input  logic          wr0_en,
    input  logic          wr1_en,
    input  logic [AW-1:0] wr0_addr,
    input  logic [AW-1:0] wr1_addr,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    input  logic          rd_ready
);

    typedef enum logic {
        RD_IDLE,
        RD_HOLD
    } rd_state_e;

    logic [W-1:0]  r_q [N];
    logic [W-1:0]  r_d [N];
    logic [W-1:0]  a_q [4];
    logic [AW-1:0] sel [4];
    logic [9:0]    cw_q;
    logic          ld_commit;
    rd_state_e     st_q;
    logic [W-1:0]  rd_data_q;
    logic          rd_valid_q;

    assign sel[0] = sel0;
    assign sel[1] = sel1;
    assign sel[2] = sel2;
    assign sel[3] = sel3;

    assign ld_ready  = !(wr0_en | wr1_en);
    assign ld_commit = ld_valid && ld_ready;

    // Post-edge register image: c1 beats c0, both beat a host load
    always_comb begin
        for (int i = 0; i < N; i++) begin
            r_d[i] = r_q[i];
            if (ld_commit && ld_addr == AW'(i))
                r_d[i] = ld_data;
            if (wr0_en && wr0_addr == AW'(i))
                r_d[i] = c0;
            if (wr1_en && wr1_addr == AW'(i))
                r_d[i] = c1;
        end
    end

    // Register file update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                r_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                r_q[i] <= r_d[i];
        end
    end

    // Operand fetch reads the post-edge image so same-edge writes forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++)
                a_q[k] <= '0;
            cw_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                a_q[k] <= r_d[sel[k]];
            cw_q <= cw_in;
        end
    end

    // Readout FSM: capture in IDLE, hold value until the host takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= RD_IDLE;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            unique case (st_q)
                RD_IDLE: begin
                    if (rd_req) begin
                        rd_data_q  <= r_d[rd_addr];
                        rd_valid_q <= 1'b1;
                        st_q       <= RD_HOLD;
                    end
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        st_q       <= RD_IDLE;
                    end
                end
                default: begin
                    rd_valid_q <= 1'b0;
                    st_q       <= RD_IDLE;
                end
            endcase
        end
    end

    assign a0       = a_q[0];
    assign a1       = a_q[1];
    assign a2       = a_q[2];
    assign a3       = a_q[3];
    assign cw       = cw_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ec_regbank.sv
// Directed bench for ec_regbank: vector table plus readout/reset sequences.
module tb_ec_regbank;

    localparam int W  = 233;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] sel0, sel1, sel2, sel3;
    logic [9:0]    cw_in;
    logic [W-1:0]  a0, a1, a2, a3;
    logic [9:0]    cw;
    logic [W-1:0]  c0, c1;
    logic          wr0_en, wr1_en;
    logic [AW-1:0] wr0_addr, wr1_addr;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_ready;

    int n_chk;
    int n_fail;

    ec_regbank #(.W(W), .N(N), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .sel0(sel0), .sel1(sel1), .sel2(sel2), .sel3(sel3),
        .cw_in(cw_in),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .cw(cw),
        .c0(c0), .c1(c1),
        .wr0_en(wr0_en), .wr1_en(wr1_en),
        .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] s0, s1, s2, s3;
        logic [9:0]    cwi;
        logic [W-1:0]  c0v, c1v;
        logic          w0, w1;
        logic [AW-1:0] w0a, w1a;
        logic          lv;
        logic [AW-1:0] la;
        logic [W-1:0]  ld;
        logic          rq;
        logic [AW-1:0] ra;
        logic          rr;
        logic          e_ldr;
        logic [W-1:0]  e_a0, e_a1, e_a2, e_a3;
        logic [9:0]    e_cw;
        logic          e_rv;
        logic [W-1:0]  e_rd;
    } vec_t;

    localparam int NV = 10;
    vec_t v [NV];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        sel0 = '0; sel1 = '0; sel2 = '0; sel3 = '0;
        cw_in = '0; c0 = '0; c1 = '0;
        wr0_en = 0; wr1_en = 0; wr0_addr = '0; wr1_addr = '0;
        ld_valid = 0; ld_addr = '0; ld_data = '0;
        rd_req = 0; rd_addr = '0; rd_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t x);
        sel0 = x.s0; sel1 = x.s1; sel2 = x.s2; sel3 = x.s3;
        cw_in = x.cwi; c0 = x.c0v; c1 = x.c1v;
        wr0_en = x.w0; wr1_en = x.w1;
        wr0_addr = x.w0a; wr1_addr = x.w1a;
        ld_valid = x.lv; ld_addr = x.la; ld_data = x.ld;
        rd_req = x.rq; rd_addr = x.ra; rd_ready = x.rr;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;

        // Load R3 then verify it landed, then reset and verify everything clears
        ld_valid = 1; ld_addr = 3'd3; ld_data = W'(233'h1AB); sel0 = 3'd3;
        tick();
        chk("pre_reset_a0", a0, W'(233'h1AB));
        idle_inputs();
        cw_in = 10'h155; sel0 = 3'd3;
        tick();
        chk("pre_reset_cw", W'(cw), W'(10'h155));
        rst_n = 0;
        #1;
        chk("reset_a0", a0, '0);
        chk("reset_cw", W'(cw), '0);
        chk("reset_rv", W'(rd_valid), '0);
        chk("reset_ldr", W'(ld_ready), W'(1'b1));
        ld_valid = 1; ld_addr = 3'd6; ld_data = W'(233'h999);
        tick();
        idle_inputs();
        #3;
        rst_n = 1;
        tick();

        for (int i = 0; i < NV; i++) v[i] = '{default: '0};
        // all registers read as zero (R3 and R6 included)
        v[0].s0 = 0; v[0].s1 = 1; v[0].s2 = 2; v[0].s3 = 3; v[0].e_ldr = 1;
        v[1].s0 = 4; v[1].s1 = 5; v[1].s2 = 6; v[1].s3 = 7; v[1].e_ldr = 1;
        // load R0=5 forwarded to every operand
        v[2].lv = 1; v[2].la = 0; v[2].ld = 5; v[2].e_ldr = 1;
        v[2].e_a0 = 5; v[2].e_a1 = 5; v[2].e_a2 = 5; v[2].e_a3 = 5;
        // load R1=9 with control word
        v[3].lv = 1; v[3].la = 1; v[3].ld = 9; v[3].cwi = 10'h2A;
        v[3].s0 = 0; v[3].s1 = 1; v[3].s2 = 1; v[3].s3 = 0; v[3].e_ldr = 1;
        v[3].e_a0 = 5; v[3].e_a1 = 9; v[3].e_a2 = 9; v[3].e_a3 = 5;
        v[3].e_cw = 10'h2A;
        // writeback forwarding into a2
        v[4].w0 = 1; v[4].w0a = 2; v[4].c0v = 'h77;
        v[4].s0 = 0; v[4].s1 = 1; v[4].s2 = 2; v[4].s3 = 3; v[4].e_ldr = 0;
        v[4].e_a0 = 5; v[4].e_a1 = 9; v[4].e_a2 = 'h77; v[4].e_a3 = 0;
        // readout R2
        v[5].rq = 1; v[5].ra = 2; v[5].s0 = 2; v[5].s1 = 2; v[5].s2 = 2;
        v[5].s3 = 2; v[5].e_ldr = 1;
        v[5].e_a0 = 'h77; v[5].e_a1 = 'h77; v[5].e_a2 = 'h77; v[5].e_a3 = 'h77;
        v[5].e_rv = 1; v[5].e_rd = 'h77;
        v[6].rr = 1; v[6].e_ldr = 1; v[6].cwi = 10'h3FF; v[6].e_cw = 10'h3FF;
        v[6].e_a0 = 5; v[6].e_a1 = 5; v[6].e_a2 = 5; v[6].e_a3 = 5;
        // double write plus load to R4: c1 wins, load blocked
        v[7].w0 = 1; v[7].w1 = 1; v[7].w0a = 4; v[7].w1a = 4;
        v[7].c0v = 'h11; v[7].c1v = 'h22;
        v[7].lv = 1; v[7].la = 4; v[7].ld = 'h33;
        v[7].s0 = 4; v[7].s1 = 4; v[7].s2 = 4; v[7].s3 = 4; v[7].e_ldr = 0;
        v[7].e_a0 = 'h22; v[7].e_a1 = 'h22; v[7].e_a2 = 'h22; v[7].e_a3 = 'h22;
        // retry the load
        v[8].lv = 1; v[8].la = 4; v[8].ld = 'h33;
        v[8].s0 = 4; v[8].s1 = 0; v[8].s2 = 1; v[8].s3 = 2; v[8].e_ldr = 1;
        v[8].e_a0 = 'h33; v[8].e_a1 = 5; v[8].e_a2 = 9; v[8].e_a3 = 'h77;
        // distinct writebacks, blocked load to R7
        v[9].w1 = 1; v[9].w1a = 5; v[9].c1v = 'hAA;
        v[9].w0 = 1; v[9].w0a = 6; v[9].c0v = 'hBB;
        v[9].lv = 1; v[9].la = 7; v[9].ld = 'hCC;
        v[9].s0 = 5; v[9].s1 = 6; v[9].s2 = 7; v[9].s3 = 4; v[9].e_ldr = 0;
        v[9].e_a0 = 'hAA; v[9].e_a1 = 'hBB; v[9].e_a2 = 0; v[9].e_a3 = 'h33;

        for (int i = 0; i < NV; i++) begin
            apply(v[i]);
            #1;
            chk($sformatf("v%0d_ldr", i), W'(ld_ready), W'(v[i].e_ldr));
            tick();
            chk($sformatf("v%0d_a0", i), a0, v[i].e_a0);
            chk($sformatf("v%0d_a1", i), a1, v[i].e_a1);
            chk($sformatf("v%0d_a2", i), a2, v[i].e_a2);
            chk($sformatf("v%0d_a3", i), a3, v[i].e_a3);
            chk($sformatf("v%0d_cw", i), W'(cw), W'(v[i].e_cw));
            chk($sformatf("v%0d_rv", i), W'(rd_valid), W'(v[i].e_rv));
            if (v[i].e_rv)
                chk($sformatf("v%0d_rd", i), rd_data, v[i].e_rd);
        end

        // Readout held across stalls, a second request and a change of R1
        idle_inputs();
        rd_req = 1; rd_addr = 3'd1;
        tick();
        chk("hold_rv0", W'(rd_valid), W'(1'b1));
        chk("hold_rd0", rd_data, W'(9));
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            if (k == 1) begin
                rd_req = 1; rd_addr = 3'd0;
            end
            if (k == 2) begin
                ld_valid = 1; ld_addr = 3'd1; ld_data = W'(233'hEE);
            end
            tick();
            chk($sformatf("hold_rv%0d", k + 1), W'(rd_valid), W'(1'b1));
            chk($sformatf("hold_rd%0d", k + 1), rd_data, W'(9));
        end
        idle_inputs();
        rd_ready = 1; rd_req = 1; rd_addr = 3'd0;
        tick();
        chk("release_rv", W'(rd_valid), '0);
        idle_inputs();
        tick();
        chk("idle_rv", W'(rd_valid), '0);
        rd_req = 1; rd_addr = 3'd0;
        tick();
        chk("fresh_rv", W'(rd_valid), W'(1'b1));
        chk("fresh_rd", rd_data, W'(5));
        idle_inputs();
        rd_req = 1; rd_addr = 3'd1;
        tick();
        chk("r1_rv", W'(rd_valid), W'(1'b1));
        chk("r1_rd", rd_data, W'(5));
        rd_ready = 1; rd_req = 0;
        tick();
        rd_ready = 0; rd_req = 1; rd_addr = 3'd1;
        tick();
        chk("r1_new_rd", rd_data, W'(233'hEE));

        // Async reset in HOLD
        idle_inputs();
        #2;
        rst_n = 0;
        #1;
        chk("async_rv", W'(rd_valid), '0);
        chk("async_rd", rd_data, '0);
        chk("async_a0", a0, '0);
        tick();
        rst_n = 1;
        sel0 = 3'd0; sel1 = 3'd1; sel2 = 3'd4; sel3 = 3'd5;
        tick();
        chk("post_r0", a0, '0);
        chk("post_r1", a1, '0);
        chk("post_r4", a2, '0);
        chk("post_r5", a3, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
